// File: rtl/sim_uart_in_responder.sv
// -----------------------------------------------------------------------------
// sim_uart_in_responder
//
// Simulation-side responder for the SimTop UART input interface. The host
// pushes characters into a small FIFO. Each read request from the DUT
// (uart_in_valid) takes one character. When no character is on offer, the
// read returns EMPTY_CH. An optional idle gap after each served character
// models line pacing.
//
// Optional feature macro: UART_IN_STATS_EN
//   When defined, this adds the served_cnt, empty_cnt and gap_cnt statistics
//   ports. Each one is a saturating 32-bit counter.
//
// Parameters
//   DEPTH       FIFO entries. Must be a power of 2 and at least 2.
//   GAP_CYCLES  Idle cycles after each served char. 0 means no gap.
//   EMPTY_CH    Value offered when no char is available.
//
// Ports
//   clock          in   single clock; all state changes on posedge
//   reset          in   asynchronous, active-high
//   host_valid     in   host push request
//   host_ch        in   char to push
//   host_ready     out  FIFO not full (taken from the registered count only)
//   uart_in_valid  in   DUT read request; one read per asserted cycle
//   uart_in_ch     out  char offered to the DUT (registered state only)
//   fifo_count     out  number of entries held
//   served_cnt     out  [UART_IN_STATS_EN] reads that popped a char
//   empty_cnt      out  [UART_IN_STATS_EN] reads answered with EMPTY_CH
//   gap_cnt        out  [UART_IN_STATS_EN] subset of empty_cnt seen in GAP
// -----------------------------------------------------------------------------
module sim_uart_in_responder #(
  parameter int          DEPTH      = 16,
  parameter int          GAP_CYCLES = 0,
  parameter logic [7:0]  EMPTY_CH   = 8'hff
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     host_valid,
  input  logic [7:0]               host_ch,
  output logic                     host_ready,
  input  logic                     uart_in_valid,
  output logic [7:0]               uart_in_ch,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef UART_IN_STATS_EN
  ,
  output logic [31:0]              served_cnt,
  output logic [31:0]              empty_cnt,
  output logic [31:0]              gap_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  // This value is only loaded when GAP_CYCLES > 0. The 0 case is never used.
  localparam logic [TW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_READY,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q, count_next;
  logic [7:0]      mem [DEPTH];
  logic            push, pop;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign host_ready = (count_q < DEPTH_C);
  assign push       = host_valid && host_ready;
  // A pop only happens while a char is offered. Reads in EMPTY or GAP do not
  // change any pointer.
  assign pop        = uart_in_valid && (state_q == S_READY);

  assign fifo_count = count_q;
  assign uart_in_ch = (state_q == S_READY) ? mem[rd_ptr] : EMPTY_CH;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents are not read until the
  // pointers and the count say so, so a reset there would only cost area.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= host_ch;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, and the order of the blocks does not
  // matter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Offer FSM
  // The next state looks at count_next rather than count_q. A char pushed in
  // one cycle is therefore already offered in the following cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // NOTE: every output of this block gets a default first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_EMPTY: begin
        if (count_next != '0) state_d = S_READY;
      end
      S_READY: begin
        if (pop) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            timer_d = GAP_LOAD;
          end else if (count_next == '0) begin
            state_d = S_EMPTY;
          end
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = (count_next != '0) ? S_READY : S_EMPTY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_EMPTY;
        timer_d = '0;
      end
    endcase
  end

`ifdef UART_IN_STATS_EN
  // ---------------------------------------------------------------------------
  // Read statistics. These are saturating counters. gap_cnt is a subset of
  // empty_cnt.
  // ---------------------------------------------------------------------------
  logic empty_read, gap_read;

  assign empty_read = uart_in_valid && (state_q != S_READY);
  assign gap_read   = uart_in_valid && (state_q == S_GAP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      served_cnt <= '0;
      empty_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      if (pop && (served_cnt != '1))       served_cnt <= served_cnt + 1'b1;
      if (empty_read && (empty_cnt != '1)) empty_cnt  <= empty_cnt + 1'b1;
      if (gap_read && (gap_cnt != '1))     gap_cnt    <= gap_cnt + 1'b1;
    end
  end
`endif

endmodule
